// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART transmit scheduler: state encoding, defaults
// and the round-robin pointer advance helper.
package uart_sched_pkg;

    localparam int NREQ_DEF    = 3;
    localparam int OWN_W_DEF   = 2;
    localparam int HOLDOFF_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic int next_ptr(input int ptr, input int nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational rotating-priority selector: first asserted req at or above
// ptr, wrapping at NREQ.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int OWN_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [OWN_W-1:0] ptr,
    output logic             valid,
    output logic [OWN_W-1:0] idx
);

    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Scan from the far end so the candidate closest to ptr wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = OWN_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Message-atomic round-robin scheduler sharing one UART transmit byte channel
// between several monitor requesters, paced against tx_rdy.
//
// state | meaning
// IDLE  | no message owned; pick next requester round-robin
// SEND  | owner holds channel; wait for tx_rdy, issue one byte
// HOLD  | post-byte holdoff while stale tx_rdy settles
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int OWN_W   = OWN_W_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    input  logic [NREQ-1:0]   last,
    output logic [NREQ-1:0]   ack,
    input  logic              tx_rdy,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [OWN_W-1:0]  owner
);

    logic [1:0]       state;
    logic [OWN_W-1:0] rr_ptr;
    logic [3:0]       hold_cnt;
    logic             last_q;
    logic             pick_valid;
    logic [OWN_W-1:0] pick_idx;

    rr_pick #(
        .NREQ  (NREQ),
        .OWN_W (OWN_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            last_q   <= 1'b0;
            ack      <= '0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            owner    <= '0;
        end else begin
            tx_en <= 1'b0;
            ack   <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        busy  <= 1'b1;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!req[owner]) begin
                        rr_ptr <= OWN_W'(next_ptr(int'(owner), NREQ));
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (tx_rdy) begin
                        tx_en      <= 1'b1;
                        tx_data    <= data[int'(owner)*8 +: 8];
                        ack[owner] <= 1'b1;
                        last_q     <= last[owner];
                        // HOLD runs HOLDOFF+1 cycles so issued bytes land HOLDOFF+2 apart.
                        hold_cnt   <= 4'(HOLDOFF);
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 4'd0) begin
                        if (last_q) begin
                            rr_ptr <= OWN_W'(next_ptr(int'(owner), NREQ));
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (NREQ=3, HOLDOFF=4).
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, last, ack;
    logic [7:0]  d0, d1, d2;
    logic [23:0] data;
    logic        tx_rdy, tx_en, busy;
    logic [7:0]  tx_data;
    logic [1:0]  owner;
    int          checks = 0;
    int          errors = 0;

    assign data = {d2, d1, d0};
    always #5 clk = ~clk;

    uart_tx_sched #(
        .NREQ    (3),
        .OWN_W   (2),
        .HOLDOFF (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data    (data),
        .last    (last),
        .ack     (ack),
        .tx_rdy  (tx_rdy),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .busy    (busy),
        .owner   (owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (tx_en) got = 1'b1;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    // Wait for one byte from requester who, check it, then retire its request.
    task automatic serve(input string tag, input int who, input logic [7:0] exp_byte);
        wait_tx(tag);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp_byte));
        chk({tag, "_ack"}, 32'(ack), 32'(1) << who);
        chk({tag, "_owner"}, 32'(owner), 32'(who));
        req[who] = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n  = 1'b0;
        req    = '0;
        last   = '0;
        d0     = 8'h00;
        d1     = 8'h00;
        d2     = 8'h00;
        tx_rdy = 1'b0;
        tick();
        tick();
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);

        // Single two-byte message from requester 1
        rst_n  = 1'b1;
        req    = 3'b010;
        d1     = 8'h41;
        tx_rdy = 1'b1;
        tick();
        chk("msg_busy", 32'(busy), 32'd1);
        chk("msg_owner", 32'(owner), 32'd1);
        chk("msg_no_early_tx", 32'(tx_en), 32'd0);
        tick();
        chk("msg_b0_en", 32'(tx_en), 32'd1);
        chk("msg_b0_data", 32'(tx_data), 32'h41);
        chk("msg_b0_ack", 32'(ack), 32'b010);
        d1   = 8'h42;
        last = 3'b010;
        cnt  = 0;
        repeat (5) begin
            tick();
            if (tx_en) cnt++;
        end
        chk("msg_gap_quiet", 32'(cnt), 32'd0);
        tick();
        chk("msg_b1_en", 32'(tx_en), 32'd1);
        chk("msg_b1_data", 32'(tx_data), 32'h42);
        chk("msg_b1_ack", 32'(ack), 32'b010);
        req  = 3'b000;
        last = 3'b000;
        repeat (4) tick();
        chk("msg_hold_busy", 32'(busy), 32'd1);
        tick();
        chk("msg_done_busy", 32'(busy), 32'd0);
        chk("msg_owner_kept", 32'(owner), 32'd1);

        // Round-robin with single-byte messages, starting from rr_ptr=0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        d0    = 8'hA0;
        d1    = 8'hA1;
        d2    = 8'hA2;
        last  = 3'b111;
        req   = 3'b111;
        serve("rr_a0", 0, 8'hA0);
        serve("rr_a1", 1, 8'hA1);
        serve("rr_a2", 2, 8'hA2);
        wait_idle("rr_a");
        req = 3'b011;
        serve("rr_b0", 0, 8'hA0);
        serve("rr_b1", 1, 8'hA1);
        wait_idle("rr_b");
        req = 3'b001;
        serve("rr_c0", 0, 8'hA0);
        wait_idle("rr_c");
        req = 3'b101;
        serve("rr_d2", 2, 8'hA2);
        serve("rr_d0", 0, 8'hA0);
        wait_idle("rr_d");

        // Atomicity: requester 2 arrives mid-message of requester 0
        last = 3'b000;
        d0   = 8'h0A;
        req  = 3'b001;
        wait_tx("at_0a");
        chk("at_0a_data", 32'(tx_data), 32'h0A);
        d0     = 8'h0B;
        req[2] = 1'b1;
        d2     = 8'h2A;
        last   = 3'b100;
        wait_tx("at_0b");
        chk("at_0b_data", 32'(tx_data), 32'h0B);
        chk("at_0b_owner", 32'(owner), 32'd0);
        d0      = 8'h0C;
        last[0] = 1'b1;
        wait_tx("at_0c");
        chk("at_0c_data", 32'(tx_data), 32'h0C);
        req[0] = 1'b0;
        serve("at_2a", 2, 8'h2A);
        wait_idle("at");

        // Backpressure in SEND
        tx_rdy = 1'b0;
        last   = 3'b111;
        d1     = 8'h55;
        req    = 3'b010;
        tick();
        chk("bp_owner", 32'(owner), 32'd1);
        cnt = 0;
        repeat (20) begin
            tick();
            if (tx_en || ack != 3'b000) cnt++;
        end
        chk("bp_quiet", 32'(cnt), 32'd0);
        tx_rdy = 1'b1;
        tick();
        chk("bp_en", 32'(tx_en), 32'd1);
        chk("bp_data", 32'(tx_data), 32'h55);
        chk("bp_ack", 32'(ack), 32'b010);
        req = 3'b000;
        wait_idle("bp");

        // Withdrawal in SEND; next pick must start above the withdrawn owner
        tx_rdy = 1'b0;
        req    = 3'b001;
        tick();
        chk("wd_owner", 32'(owner), 32'd0);
        chk("wd_busy", 32'(busy), 32'd1);
        req = 3'b000;
        tick();
        chk("wd_idle_busy", 32'(busy), 32'd0);
        chk("wd_no_tx", 32'(tx_en), 32'd0);
        chk("wd_no_ack", 32'(ack), 32'd0);
        d0  = 8'hB0;
        d1  = 8'hB1;
        d2  = 8'hB2;
        req = 3'b111;
        tick();
        chk("wd_next_owner", 32'(owner), 32'd1);

        // Reset asserted during HOLD
        tx_rdy = 1'b1;
        tick();
        chk("rm_en", 32'(tx_en), 32'd1);
        chk("rm_data", 32'(tx_data), 32'hB1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rm_tx_en", 32'(tx_en), 32'd0);
        chk("rm_ack", 32'(ack), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;
        req   = 3'b101;
        tick();
        chk("rm_ptr_zero", 32'(owner), 32'd0);
        serve("rm_b0", 0, 8'hB0);
        serve("rm_b2", 2, 8'hB2);
        wait_idle("rm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
